// File: rtl/dll_tx_retry.sv
// Data-link transmit stage: sequence numbering, retry buffer, Ack/Nak handling
// and timer-driven replay towards the PHY framer.
module dll_tx_retry #(
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int REPLAY_TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [255:0]               tlp_i,
  input  logic [2:0]                 req_i,
  input  logic                       link_active_i,
  output logic [RETRY_DEPTH_LG2+2:0] retry_buffer_leftover_cnt_o,
  output logic [255:0]               phy_tdata_o,
  output logic [11:0]                phy_tseq_o,
  output logic                       phy_tsop_o,
  output logic                       phy_teop_o,
  output logic                       phy_tvalid_o,
  input  logic                       phy_tready_i,
  input  logic                       ack_valid_i,
  input  logic                       ack_nak_i,
  input  logic [11:0]                ack_seq_i,
  output logic                       ack_ready_o,
  output logic [11:0]                next_seq_o,
  output logic [11:0]                ackd_seq_o,
  output logic                       retrain_o
);
  localparam int PW    = RETRY_DEPTH_LG2;
  localparam int CW    = RETRY_DEPTH_LG2 + 1;
  localparam int OW    = RETRY_DEPTH_LG2 + 3;
  localparam int DEPTH = 1 << RETRY_DEPTH_LG2;
  localparam int TW    = $clog2(REPLAY_TIMEOUT + 1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPLAY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PURGE, REPLAY_WAIT, REPLAY} state_t;
  typedef struct packed {logic sop; logic eop; logic [11:0] seq;} sb_t;

  logic [255:0] mem_data [DEPTH];
  sb_t          mem_sb   [DEPTH];

  state_t        state_reg;
  logic [PW-1:0] wr_ptr_reg, tx_ptr_reg, ack_ptr_reg, replay_end_reg;
  logic [CW-1:0] count_reg;
  logic [11:0]   next_seq_reg, ackd_seq_reg;
  logic [1:0]    replay_num_reg;
  logic [TW-1:0] timer_reg;
  logic          nak_pend_reg, mid_tlp_reg, retrain_reg;
  logic          hold_valid_reg, hold_sop_reg;
  logic [255:0]  hold_data_reg;
  logic [255:0]  tx_data_reg;
  sb_t           tx_sb_reg;

  logic          flush, capture, is_hdr, wr_eop, wr_en;
  logic          tx_valid, tx_fire, acc, in_win, ack_take, nak_replay, timer_exp;
  logic          purge_pop, purge_end, enter_rw, replay_start, ack_eop;
  logic [11:0]   ack_seq_at_ptr, d, u;
  logic [PW-1:0] rd_addr;
  sb_t           wr_sb;

  assign flush   = rst || !link_active_i;
  assign capture = (req_i == 3'd1) || (req_i == 3'd2) || (req_i == 3'd3) ||
                   (req_i == 3'd5) || (req_i == 3'd6);
  assign is_hdr  = (req_i == 3'd1) || (req_i == 3'd3) || (req_i == 3'd5);
  assign wr_eop  = !((req_i == 3'd2) || (req_i == 3'd6));
  // A write into a full buffer is dropped; flow control should never allow it.
  assign wr_en   = hold_valid_reg && (count_reg != CNT_FULL) && !flush;
  assign wr_sb   = '{sop: hold_sop_reg, eop: wr_eop, seq: next_seq_reg};

  // Mid-TLP in REPLAY_WAIT the current TLP must still be finished before stalling.
  assign tx_valid = (tx_ptr_reg != wr_ptr_reg) &&
                    ((state_reg == IDLE) || (state_reg == REPLAY) ||
                     ((state_reg == REPLAY_WAIT) && mid_tlp_reg));
  assign tx_fire  = tx_valid && phy_tready_i;

  assign ack_eop        = mem_sb[ack_ptr_reg].eop;
  assign ack_seq_at_ptr = mem_sb[ack_ptr_reg].seq;

  assign acc        = ack_valid_i && (state_reg == IDLE);
  assign d          = ack_seq_i - ackd_seq_reg;
  assign u          = next_seq_reg - 12'd1 - ackd_seq_reg;
  assign in_win     = (d != 12'd0) && (d <= u);
  assign ack_take   = acc && in_win;
  assign nak_replay = acc && ack_nak_i && (d == 12'd0);
  assign timer_exp  = (state_reg == IDLE) && !ack_take && !nak_replay &&
                      (ack_ptr_reg != wr_ptr_reg) && (timer_reg == TIMER_LAST);
  assign purge_pop  = (state_reg == PURGE) && (ack_ptr_reg != wr_ptr_reg);
  assign purge_end  = (state_reg == PURGE) && ((ack_ptr_reg == wr_ptr_reg) ||
                      (ack_eop && (ack_seq_at_ptr == ackd_seq_reg)));
  assign enter_rw     = nak_replay || timer_exp || (purge_end && nak_pend_reg);
  assign replay_start = (state_reg == REPLAY_WAIT) && !mid_tlp_reg;

  // Read address tracks the tx pointer's next value so the registered read lines up.
  assign rd_addr = flush        ? '0 :
                   replay_start ? ack_ptr_reg :
                   tx_fire      ? tx_ptr_reg + PTR_ONE : tx_ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_reg] <= hold_data_reg;
      mem_sb[wr_ptr_reg]   <= wr_sb;
    end
    if (wr_en && (wr_ptr_reg == rd_addr)) begin
      tx_data_reg <= hold_data_reg;
      tx_sb_reg   <= wr_sb;
    end else begin
      tx_data_reg <= mem_data[rd_addr];
      tx_sb_reg   <= mem_sb[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      tx_ptr_reg     <= '0;
      ack_ptr_reg    <= '0;
      replay_end_reg <= '0;
      count_reg      <= '0;
      next_seq_reg   <= 12'd0;
      ackd_seq_reg   <= 12'd4095;
      replay_num_reg <= 2'd0;
      timer_reg      <= '0;
      nak_pend_reg   <= 1'b0;
      mid_tlp_reg    <= 1'b0;
      retrain_reg    <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_sop_reg   <= 1'b0;
      hold_data_reg  <= '0;
    end else begin
      hold_valid_reg <= capture;
      if (capture) begin
        hold_data_reg <= tlp_i;
        hold_sop_reg  <= is_hdr;
      end
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (wr_eop) next_seq_reg <= next_seq_reg + 12'd1;
      end
      count_reg <= count_reg + (wr_en ? CNT_ONE : '0) - (purge_pop ? CNT_ONE : '0);
      if (tx_fire) begin
        tx_ptr_reg  <= tx_ptr_reg + PTR_ONE;
        mid_tlp_reg <= !tx_sb_reg.eop;
      end
      if (purge_pop) ack_ptr_reg <= ack_ptr_reg + PTR_ONE;

      retrain_reg <= 1'b0;
      if (enter_rw) begin
        if (replay_num_reg == 2'd3) begin
          retrain_reg    <= 1'b1;
          replay_num_reg <= 2'd0;
        end else begin
          replay_num_reg <= replay_num_reg + 2'd1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (ack_take || (ack_ptr_reg == wr_ptr_reg)) timer_reg <= '0;
          else timer_reg <= timer_reg + TW'(1);
          if (ack_take) begin
            ackd_seq_reg   <= ack_seq_i;
            replay_num_reg <= 2'd0;
            nak_pend_reg   <= ack_nak_i;
            state_reg      <= PURGE;
          end else if (enter_rw) begin
            state_reg <= REPLAY_WAIT;
          end
        end
        PURGE: begin
          if (purge_end) state_reg <= nak_pend_reg ? REPLAY_WAIT : IDLE;
        end
        REPLAY_WAIT: begin
          if (replay_start) begin
            tx_ptr_reg     <= ack_ptr_reg;
            timer_reg      <= '0;
            replay_end_reg <= wr_ptr_reg;
            state_reg      <= REPLAY;
          end
        end
        default: begin
          if (tx_ptr_reg == replay_end_reg) state_reg <= IDLE;
        end
      endcase
    end
  end

  assign retry_buffer_leftover_cnt_o = OW'({count_reg, 3'b000});
  assign phy_tdata_o  = tx_data_reg;
  assign phy_tseq_o   = tx_sb_reg.seq;
  assign phy_tsop_o   = tx_sb_reg.sop;
  assign phy_teop_o   = tx_sb_reg.eop;
  assign phy_tvalid_o = tx_valid;
  assign ack_ready_o  = (state_reg == IDLE);
  assign next_seq_o   = next_seq_reg;
  assign ackd_seq_o   = ackd_seq_reg;
  assign retrain_o    = retrain_reg;
endmodule

// File: tb/tb_dll_tx_retry.sv
// Directed bench for dll_tx_retry: sequencing, purge, Nak/timer replay,
// retrain escalation, egress backpressure and link-down flush.
module tb_dll_tx_retry;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] tlp;
  logic [2:0]   req;
  logic         link_active;
  logic [10:0]  leftover;
  logic [255:0] tdata;
  logic [11:0]  tseq;
  logic         tsop, teop, tvalid, tready;
  logic         ack_valid, ack_nak;
  logic [11:0]  ack_seq;
  logic         ack_ready;
  logic [11:0]  next_seq, ackd_seq;
  logic         retrain;

  int checks = 0;
  int errors = 0;
  int retrain_cnt = 0;

  typedef struct packed {logic [255:0] d; logic [11:0] s; logic sop; logic eop;} beat_t;
  beat_t txq[$];

  localparam logic [255:0] A  = {8{32'hA0A0_0001}};
  localparam logic [255:0] B  = {8{32'hB1B1_0002}};
  localparam logic [255:0] C  = {8{32'hC2C2_0003}};
  localparam logic [255:0] D  = {8{32'hD3D3_0004}};
  localparam logic [255:0] E  = {8{32'hE4E4_0005}};

  always #5 clk = ~clk;

  dll_tx_retry #(.RETRY_DEPTH_LG2(8), .REPLAY_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .tlp_i(tlp), .req_i(req), .link_active_i(link_active),
    .retry_buffer_leftover_cnt_o(leftover),
    .phy_tdata_o(tdata), .phy_tseq_o(tseq), .phy_tsop_o(tsop), .phy_teop_o(teop),
    .phy_tvalid_o(tvalid), .phy_tready_i(tready),
    .ack_valid_i(ack_valid), .ack_nak_i(ack_nak), .ack_seq_i(ack_seq),
    .ack_ready_o(ack_ready), .next_seq_o(next_seq), .ackd_seq_o(ackd_seq),
    .retrain_o(retrain)
  );

  always @(negedge clk) begin
    if (tvalid && tready) begin
      txq.push_back('{d: tdata, s: tseq, sop: tsop, eop: teop});
      $display("beat seq=%0d sop=%0b eop=%0b data=%h", tseq, tsop, teop, tdata[31:0]);
    end
    if (retrain) retrain_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] r, input logic [255:0] t);
    req = r;
    tlp = t;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; link_active = 1'b1; req = 3'd0; tlp = '0; tready = 1'b1;
    ack_valid = 1'b0; ack_nak = 1'b0; ack_seq = 12'd0;
    tick(); tick();
    rst = 1'b0;
    txq.delete();
    retrain_cnt = 0;
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 50 && !ack_ready; i++) tick();
    ok = ack_ready;
  endtask

  task automatic dllp(input logic nak, input logic [11:0] s);
    ack_valid = 1'b1; ack_nak = nak; ack_seq = s;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b need 0", tvalid); end
    checks++; if (ack_ready !== 1'b1) begin errors++; $display("FAIL reset_ack_ready got %b need 1", ack_ready); end
    checks++; if (leftover !== 11'd0) begin errors++; $display("FAIL reset_count got %0d need 0", leftover); end
    checks++; if (next_seq !== 12'd0) begin errors++; $display("FAIL reset_next_seq got %0d need 0", next_seq); end
    checks++; if (ackd_seq !== 12'd4095) begin errors++; $display("FAIL reset_ackd got %0d need 4095", ackd_seq); end
    checks++; if (retrain !== 1'b0) begin errors++; $display("FAIL reset_retrain got %b need 0", retrain); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    send(3'd3, A);
    send(3'd7, '0);
    req = 3'd0;
    checks++; if (leftover !== 11'd8) begin errors++; $display("FAIL t1_count got %0d need 8", leftover); end
    checks++; if (next_seq !== 12'd1) begin errors++; $display("FAIL t1_next_seq got %0d need 1", next_seq); end
    checks++; if (tvalid !== 1'b1 || tdata !== A || tsop !== 1'b1 || teop !== 1'b1 || tseq !== 12'd0) begin
      errors++; $display("FAIL t1_beat got v=%b sop=%b eop=%b seq=%0d d=%h need 1 1 1 0 A", tvalid, tsop, teop, tseq, tdata[31:0]);
    end
    tick(); tick();
    checks++; if (txq.size() !== 1) begin errors++; $display("FAIL t1_beats got %0d need 1", txq.size()); end
    wait_ready(ok);
    dllp(1'b0, 12'd0);
    checks++; if (ack_ready !== 1'b0 || ackd_seq !== 12'd0) begin
      errors++; $display("FAIL t1_purge_state got ready=%b ackd=%0d need 0 0", ack_ready, ackd_seq);
    end
    tick();
    checks++; if (leftover !== 11'd0 || ack_ready !== 1'b1) begin
      errors++; $display("FAIL t1_purged got cnt=%0d ready=%b need 0 1", leftover, ack_ready);
    end
  endtask

  task automatic test_multi_beat();
    bit ok;
    beat_t exp [5];
    exp[0] = '{d: A, s: 12'd0, sop: 1'b1, eop: 1'b0};
    exp[1] = '{d: B, s: 12'd0, sop: 1'b0, eop: 1'b0};
    exp[2] = '{d: C, s: 12'd0, sop: 1'b0, eop: 1'b1};
    exp[3] = '{d: D, s: 12'd1, sop: 1'b1, eop: 1'b0};
    exp[4] = '{d: E, s: 12'd1, sop: 1'b0, eop: 1'b1};
    do_reset();
    send(3'd1, A); send(3'd2, B); send(3'd2, C); send(3'd7, '0);
    send(3'd5, D); send(3'd6, E); send(3'd7, '0);
    req = 3'd0;
    checks++; if (leftover !== 11'd40) begin errors++; $display("FAIL t2_count got %0d need 40", leftover); end
    tick(); tick(); tick();
    checks++; if (txq.size() !== 5) begin errors++; $display("FAIL t2_beats got %0d need 5", txq.size()); end
    for (int i = 0; i < 5 && i < txq.size(); i++) begin
      checks++; if (txq[i] !== exp[i]) begin
        errors++; $display("FAIL t2_beat%0d got seq=%0d sop=%b eop=%b d=%h need seq=%0d sop=%b eop=%b d=%h",
          i, txq[i].s, txq[i].sop, txq[i].eop, txq[i].d[31:0], exp[i].s, exp[i].sop, exp[i].eop, exp[i].d[31:0]);
      end
    end
    wait_ready(ok);
    dllp(1'b0, 12'd0);
    for (int i = 0; i < 10 && !ack_ready; i++) tick();
    checks++; if (leftover !== 11'd16 || ackd_seq !== 12'd0) begin
      errors++; $display("FAIL t2_purge got cnt=%0d ackd=%0d need 16 0", leftover, ackd_seq);
    end
  endtask

  task automatic test_nak_replay();
    bit ok;
    do_reset();
    send(3'd3, A); send(3'd3, B); send(3'd3, C); send(3'd7, '0);
    req = 3'd0;
    tick(); tick(); tick();
    checks++; if (txq.size() !== 3) begin errors++; $display("FAIL t3_first_pass got %0d need 3", txq.size()); end
    txq.delete();
    wait_ready(ok);
    dllp(1'b1, 12'd0);
    for (int i = 0; i < 30 && !(txq.size() >= 2 && ack_ready); i++) tick();
    checks++; if (txq.size() !== 2) begin errors++; $display("FAIL t3_replay_beats got %0d need 2", txq.size()); end
    if (txq.size() == 2) begin
      checks++; if (txq[0].s !== 12'd1 || txq[0].d !== B || txq[1].s !== 12'd2 || txq[1].d !== C) begin
        errors++; $display("FAIL t3_replay_order got %0d/%h %0d/%h need 1/B 2/C", txq[0].s, txq[0].d[31:0], txq[1].s, txq[1].d[31:0]);
      end
    end
    checks++; if (leftover !== 11'd16 || ackd_seq !== 12'd0) begin
      errors++; $display("FAIL t3_after_nak got cnt=%0d ackd=%0d need 16 0", leftover, ackd_seq);
    end
    wait_ready(ok);
    dllp(1'b0, 12'd5);
    tick();
    checks++; if (leftover !== 11'd16 || ackd_seq !== 12'd0 || ack_ready !== 1'b1) begin
      errors++; $display("FAIL t3_out_of_window got cnt=%0d ackd=%0d ready=%b need 16 0 1", leftover, ackd_seq, ack_ready);
    end
  endtask

  task automatic test_timer_replay();
    bit ok;
    int n;
    do_reset();
    send(3'd3, D); send(3'd7, '0);
    req = 3'd0;
    n = 0;
    while (n < 1200 && txq.size() < 2) begin tick(); n++; end
    checks++; if (n < 1015 || n > 1040) begin errors++; $display("FAIL t4_timeout got %0d cycles need 1015..1040", n); end
    if (txq.size() == 2) begin
      checks++; if (txq[1].s !== 12'd0 || txq[1].d !== D) begin
        errors++; $display("FAIL t4_replay_beat got %0d/%h need 0/D", txq[1].s, txq[1].d[31:0]);
      end
    end
    wait_ready(ok);
    dllp(1'b0, 12'd0);
    tick(); tick();
    checks++; if (leftover !== 11'd0 || ackd_seq !== 12'd0) begin
      errors++; $display("FAIL t4_ack got cnt=%0d ackd=%0d need 0 0", leftover, ackd_seq);
    end
    for (int i = 0; i < 1100; i++) tick();
    checks++; if (txq.size() !== 2) begin errors++; $display("FAIL t4_no_rereplay got %0d beats need 2", txq.size()); end
  endtask

  task automatic test_retrain();
    bit ok;
    do_reset();
    send(3'd3, E); send(3'd7, '0);
    req = 3'd0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t5_ready_wait%0d got 0 need 1", k); end
      dllp(1'b1, 12'd4095);
      for (int i = 0; i < 20 && !(txq.size() >= 2 + k && ack_ready); i++) tick();
      if (k == 2) begin
        checks++; if (retrain_cnt !== 0) begin errors++; $display("FAIL t5_early_retrain got %0d need 0", retrain_cnt); end
      end
    end
    tick(); tick();
    checks++; if (retrain_cnt !== 1) begin errors++; $display("FAIL t5_retrain got %0d pulses need 1", retrain_cnt); end
    checks++; if (txq.size() !== 5) begin errors++; $display("FAIL t5_beats got %0d need 5", txq.size()); end
  endtask

  task automatic test_backpressure_link_down();
    logic [255:0] exp_d [6];
    exp_d[0] = A; exp_d[1] = B; exp_d[2] = C; exp_d[3] = A; exp_d[4] = B; exp_d[5] = C;
    do_reset();
    tready = 1'b0;
    send(3'd1, A); send(3'd2, B); send(3'd2, C); send(3'd7, '0);
    req = 3'd0;
    tick();
    checks++; if (tvalid !== 1'b1 || tdata !== A) begin errors++; $display("FAIL t6_hold_hdr got v=%b d=%h need 1 A", tvalid, tdata[31:0]); end
    tready = 1'b1;
    tick();
    tready = 1'b0;
    dllp(1'b1, 12'd4095);
    for (int i = 0; i < 5; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== B || tsop !== 1'b0) begin
        errors++; $display("FAIL t6_stable%0d got v=%b sop=%b d=%h need 1 0 B", i, tvalid, tsop, tdata[31:0]);
      end
      tick();
    end
    tready = 1'b1;
    for (int i = 0; i < 20 && !(txq.size() >= 6 && ack_ready); i++) tick();
    checks++; if (txq.size() !== 6) begin errors++; $display("FAIL t6_beats got %0d need 6", txq.size()); end
    for (int i = 0; i < 6 && i < txq.size(); i++) begin
      checks++; if (txq[i].d !== exp_d[i] || txq[i].s !== 12'd0) begin
        errors++; $display("FAIL t6_beat%0d got %0d/%h need 0/%h", i, txq[i].s, txq[i].d[31:0], exp_d[i][31:0]);
      end
    end
    link_active = 1'b0;
    tick();
    checks++; if (tvalid !== 1'b0 || leftover !== 11'd0 || next_seq !== 12'd0 || ackd_seq !== 12'd4095 ||
                  ack_ready !== 1'b1 || retrain !== 1'b0) begin
      errors++; $display("FAIL t6_link_down got v=%b cnt=%0d next=%0d ackd=%0d rdy=%b rt=%b need 0 0 0 4095 1 0",
        tvalid, leftover, next_seq, ackd_seq, ack_ready, retrain);
    end
    link_active = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_beat();
    test_nak_replay();
    test_timer_replay();
    test_retrain();
    test_backpressure_link_down();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
